// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam int         PAUSE_SKIP = 7;

    // Keyboard responses (ACK, BAT ok, echo, resend, overrun) that carry no key
    localparam int         N_IGNORE = 6;
    localparam logic [7:0] IGNORE_CODES [N_IGNORE] =
        '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IGNORE; i++) begin
            if (code == IGNORE_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 pin conditioning and 11-bit frame receiver: start, 8 data LSB first,
// odd parity, stop. One byte_vld or err pulse per frame.
//   state  | meaning
//   IDLE   | waiting for start bit edge
//   DATA   | shifting in 8 data bits
//   PARITY | capturing parity bit
//   STOP   | checking stop bit, then report byte or error
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       err
);

    localparam int            FW        = $clog2(FILTER_LEN + 1);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
    // Two cycles short: one for the err register here, one for the output stage
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT - 2);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_lvl;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          dat;

    frame_state_t  state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_ok, par_ok_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          vld_nxt, err_nxt;

    assign dat       = dat_sync[1];
    assign fall      = clk_lvl & ~clk_sync[1] & (filt_cnt == '0);
    assign byte_data = shreg;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_lvl  <= 1'b1;
            filt_cnt <= FILT_LOAD;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            if (clk_sync[1] == clk_lvl) begin
                filt_cnt <= FILT_LOAD;
            end else if (filt_cnt == '0) begin
                clk_lvl  <= clk_sync[1];
                filt_cnt <= FILT_LOAD;
            end else begin
                filt_cnt <= filt_cnt - FW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            tmo_cnt  <= '0;
            byte_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            par_ok   <= par_ok_nxt;
            tmo_cnt  <= tmo_nxt;
            byte_vld <= vld_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_ok_nxt  = par_ok;
        tmo_nxt     = tmo_cnt;
        vld_nxt     = 1'b0;
        err_nxt     = 1'b0;

        if (fall) begin
            tmo_nxt = TMO_LOAD;
        end else if (state != IDLE && tmo_cnt != '0) begin
            tmo_nxt = tmo_cnt - TW'(1);
        end

        if (state != IDLE && !fall && tmo_cnt == '0) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                DATA: begin
                    shreg_nxt   = {dat, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_ok_nxt = ^{shreg, dat};
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (par_ok && dat) vld_nxt = 1'b1;
                    else               err_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: resolves E0/F0/E1 prefixes on received bytes and
// produces the toggle-strobed 11-bit key event word.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err
);

    logic       byte_vld;
    logic [7:0] byte_data;
    logic       err;
    logic       ext;
    logic       rel;
    logic [2:0] skip;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk_sys   (clk_sys),
        .rst       (RESET),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .err       (err)
    );

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            ps2_key   <= '0;
            key_stb   <= 1'b0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            skip      <= '0;
        end else begin
            key_stb   <= 1'b0;
            frame_err <= err;
            if (err) begin
                ext  <= 1'b0;
                rel  <= 1'b0;
                skip <= '0;
            end else if (byte_vld) begin
                // The pause key sends E1 plus seven more bytes and no break
                if (skip != '0) begin
                    skip <= skip - 3'd1;
                end else if (byte_data == PS2_PAUSE) begin
                    skip <= 3'(PAUSE_SKIP);
                end else if (byte_data == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (byte_data == PS2_REL) begin
                    rel <= 1'b1;
                end else if (!is_ignored(byte_data)) begin
                    ps2_key <= {~ps2_key[10], ~rel, ext, byte_data};
                    key_stb <= 1'b1;
                    ext     <= 1'b0;
                    rel     <= 1'b0;
                end
            end
        end
    end

endmodule
